// File: rtl/sram_dp_pkg.sv
// Shared definitions for the parametrised dual-port SRAM with clear engine:
// read-during-write mode constants, the clear FSM state type and the
// byte-lane merge helper used by the port read paths.
package sram_dp_pkg;

  // Same-port read-during-write behaviour
  localparam int READ_FIRST    = 0;  // a write returns the word as it was before the edge
  localparam int WRITE_THROUGH = 1;  // a write returns the old word with enabled lanes replaced

  // The merge helper works on a fixed wide vector so that one function
  // serves every DATA_WIDTH. Callers zero-extend their operands and
  // truncate the result back to their own width.
  localparam int unsigned MERGE_MAX_WIDTH = 256;
  localparam int unsigned MERGE_IDX_W     = $clog2(MERGE_MAX_WIDTH);

  typedef logic [MERGE_MAX_WIDTH-1:0] merge_word_t;

  // Clear engine states. CLEAR is the reset state so the array is
  // initialised automatically after every reset.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  // Returns old_word with every byte lane whose lane_mask bit is set
  // replaced by the matching lane of new_word. Bit i of lane_mask
  // controls bits [i*byte_width +: byte_width].
  function automatic merge_word_t byte_merge(
    input merge_word_t old_word,
    input merge_word_t new_word,
    input merge_word_t lane_mask,
    input int unsigned byte_width
  );
    merge_word_t            merged;
    logic [MERGE_IDX_W-1:0] lane;
    logic [MERGE_IDX_W-1:0] bit_idx;
    merged = old_word;
    for (int unsigned b = 0; b < MERGE_MAX_WIDTH; b++) begin
      bit_idx = MERGE_IDX_W'(b);
      lane    = MERGE_IDX_W'(b / byte_width);
      if (lane_mask[lane]) begin
        merged[bit_idx] = new_word[bit_idx];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_dp_port.sv
// One access port's read path: selects the returned word according to the
// read-during-write mode, registers it, and optionally adds a second output
// register. The valid flag travels alongside the data so that it always
// marks the cycle in which dataOut carries a fresh read result.
module sram_dp_port
  import sram_dp_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int BYTE_WIDTH = 8,
  parameter  int READ_MODE  = READ_FIRST,
  parameter  int OUTPUT_REG = 0,
  localparam int NB         = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  req,       // access accepted this cycle (already gated by busy)
  input  logic                  write,     // the accepted access is a write
  input  logic [NB-1:0]         byte_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] old_word,  // array contents at the addressed word before this edge
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] read_word;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  // Pick the word to return: the old word, or the merged word for write-through writes
  // NOTE: the default assignment first keeps this block purely combinational; without it a
  // path that skips the assignment would infer a latch.
  always_comb begin
    read_word = old_word;
    if (READ_MODE == WRITE_THROUGH && write) begin
      read_word = DATA_WIDTH'(byte_merge(merge_word_t'(old_word), merge_word_t'(data_in),
                                         merge_word_t'(byte_en), unsigned'(BYTE_WIDTH)));
    end
  end

  // First read stage: capture the word on every accepted access, hold it otherwise
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values,
  // independent of the order in which always blocks are evaluated.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= req;
      if (req) begin
        s1_data <= read_word;
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      // Second read stage: free-running pipeline, data only moves when it is valid
      always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign data_out = s2_data;
      assign valid    = s2_valid;
    end else begin : g_no_out_reg
      assign data_out = s1_data;
      assign valid    = s1_valid;
    end
  endgenerate

endmodule

// File: rtl/sram_dual_port_clr.sv
// Parametrised single-clock true dual-port SRAM with per-byte write enables,
// selectable read-during-write behaviour, optional output register and a
// hardware clear engine that writes CLEAR_VALUE to every word after reset
// or on request. While the clear engine runs, both ports are locked out.
//
// The array is built as one bank per byte lane. Each bank sees at most one
// write per port per cycle, and the A-over-B priority on a shared address is
// resolved per lane, which is exactly the collision rule: overlapping lanes
// take A's data, non-overlapping lanes from B still land.
//
// DATA_WIDTH must be a multiple of BYTE_WIDTH and at most 256 bits.
module sram_dual_port_clr
  import sram_dp_pkg::*;
#(
  parameter  int                    DATA_WIDTH  = 16,
  parameter  int                    BYTE_WIDTH  = 8,
  parameter  int                    ADDR_WIDTH  = 10,
  parameter  int                    READ_MODE   = READ_FIRST,
  parameter  int                    OUTPUT_REG  = 0,
  parameter  logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int                    NB          = DATA_WIDTH / BYTE_WIDTH,
  localparam int                    DEPTH       = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  clearRequest,
  output logic                  busy,
  output logic                  collision,
  input  logic                  enableA,
  input  logic                  writeEnableA,
  input  logic [NB-1:0]         byteEnableA,
  input  logic [ADDR_WIDTH-1:0] addressA,
  input  logic [DATA_WIDTH-1:0] dataInA,
  output logic [DATA_WIDTH-1:0] dataOutA,
  output logic                  validA,
  input  logic                  enableB,
  input  logic                  writeEnableB,
  input  logic [NB-1:0]         byteEnableB,
  input  logic [ADDR_WIDTH-1:0] addressB,
  input  logic [DATA_WIDTH-1:0] dataInB,
  output logic [DATA_WIDTH-1:0] dataOutB,
  output logic                  validB
);

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  clr_state_t            state;
  clr_state_t            next_state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;

  // State register and clear address counter; reset restarts the clear at word 0
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) begin
        // Wraps to 0 after the last word, which is also the IDLE entry value
        clr_addr <= clr_addr + ADDR_WIDTH'(1);
      end else if (clearRequest) begin
        clr_addr <= '0;
      end
    end
  end

  // Next-state logic: finish after the last word, restart only from IDLE
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) next_state = IDLE;
      IDLE:    if (clearRequest)                      next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  // Output logic: busy and the clear write strobe are both "in CLEAR"
  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    case (state)
      CLEAR:   begin busy = 1'b1; clr_we = 1'b1; end
      IDLE:    begin busy = 1'b0; clr_we = 1'b0; end
      default: begin busy = 1'b1; clr_we = 1'b1; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request qualification and collision detection
  // ---------------------------------------------------------------------------
  logic req_a;
  logic req_b;
  logic wr_a;
  logic wr_b;
  logic same_addr;
  logic collide;

  assign req_a     = enableA & ~busy;
  assign req_b     = enableB & ~busy;
  assign wr_a      = req_a & writeEnableA;
  assign wr_b      = req_b & writeEnableB;
  assign same_addr = (addressA == addressB);
  assign collide   = wr_a & wr_b & same_addr & (|(byteEnableA & byteEnableB));

  // Registered collision pulse, one cycle after the colliding writes
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      collision <= 1'b0;
    end else begin
      collision <= collide;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-lane banks
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] old_a;
  logic [DATA_WIDTH-1:0] old_b;

  generate
    for (genvar l = 0; l < NB; l++) begin : g_lane
      logic [BYTE_WIDTH-1:0] bank [DEPTH];
      logic                  lane_wr_a;
      logic                  lane_wr_b;

      assign lane_wr_a = wr_a & byteEnableA[l];
      // Port A owns a lane it is writing at the same address; B's lane is dropped
      assign lane_wr_b = wr_b & byteEnableB[l] & ~(lane_wr_a & same_addr);

      // Lane bank write: clear engine has exclusive access while it runs
      // NOTE: the bank has no reset branch on purpose; a reset cannot touch thousands of
      // words at once, so the clear engine alone defines the contents.
      always_ff @(posedge clock) begin
        if (clr_we) begin
          bank[clr_addr] <= CLEAR_VALUE[l*BYTE_WIDTH +: BYTE_WIDTH];
        end else begin
          if (lane_wr_a) begin
            bank[addressA] <= dataInA[l*BYTE_WIDTH +: BYTE_WIDTH];
          end
          if (lane_wr_b) begin
            bank[addressB] <= dataInB[l*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end

      // Pre-edge contents feed both read paths, giving read-first cross-port behaviour
      assign old_a[l*BYTE_WIDTH +: BYTE_WIDTH] = bank[addressA];
      assign old_b[l*BYTE_WIDTH +: BYTE_WIDTH] = bank[addressB];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Port read paths
  // ---------------------------------------------------------------------------
  sram_dp_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .READ_MODE  (READ_MODE),
    .OUTPUT_REG (OUTPUT_REG)
  ) u_port_a (
    .clock    (clock),
    .resetN   (resetN),
    .req      (req_a),
    .write    (writeEnableA),
    .byte_en  (byteEnableA),
    .data_in  (dataInA),
    .old_word (old_a),
    .data_out (dataOutA),
    .valid    (validA)
  );

  sram_dp_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .READ_MODE  (READ_MODE),
    .OUTPUT_REG (OUTPUT_REG)
  ) u_port_b (
    .clock    (clock),
    .resetN   (resetN),
    .req      (req_b),
    .write    (writeEnableB),
    .byte_en  (byteEnableB),
    .data_in  (dataInB),
    .old_word (old_b),
    .data_out (dataOutB),
    .valid    (validB)
  );

endmodule

// File: doc/sram_dual_port_clr.md
# sram_dual_port_clr

Parametrised single-clock true dual-port SRAM, successor to the fixed 1024x16 dual-port memory used by the support modules. Adds:
- configurable width and depth
- per-byte write enables
- selectable same-port read-during-write mode
- optional output register stage with valid flags
- deterministic cross-port write-collision resolution
- a hardware clear engine that initialises every word after reset or on request

Sits between bus-side DMA/CPU ports and local buffers wherever the fixed 1024x16 instance was used.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH words, exactly (indices 0..DEPTH-1)
- READ_MODE, 0, same-port read-during-write: 0 = read-first (old word), 1 = write-through (merged new word)
- OUTPUT_REG, 0, 0 = 1-cycle read latency, 1 = 2-cycle (extra output register)
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written by the clear engine
- clock  in  1  single clock for both ports; all logic on rising edge
- resetN  in  1  asynchronous, active-low reset
- clearRequest  in  1  start clear engine; sampled only in IDLE
- busy  out  1  clear engine running; port requests ignored
- collision  out  1  one-cycle pulse: A and B wrote the same address with overlapping byte enables
- enableA / enableB  in  1  port access request
- writeEnableA / writeEnableB  in  1  write (1) or read (0) when enabled
- byteEnableA / byteEnableB  in  NB  per-lane write mask
- addressA / addressB  in  ADDR_WIDTH  word address
- dataInA / dataInB  in  DATA_WIDTH  write data
- dataOutA / dataOutB  out  DATA_WIDTH  read data
- validA / validB  out  1  dataOut carries the result of a read issued 1 (or 2) cycles earlier

## Operation
- Every enabled access returns data, writes included: a write returns the word per READ_MODE.
- Clear FSM states:
  - CLEAR: entered asynchronously on resetN low. Counter starts at 0 and writes CLEAR_VALUE to one address per cycle. The last address (DEPTH-1) is written, then the FSM moves to IDLE. busy=1 throughout.
  - IDLE: busy=0. clearRequest=1 loads counter=0 and moves to CLEAR on the next edge.
- A clear takes exactly DEPTH cycles.
- While busy=1, enableA/enableB are ignored: no writes, valid stays 0.
- Memory array has no reset; contents are defined only by the clear engine.
- resetN asserted mid-clear restarts the clear from address 0.
- clearRequest while busy is ignored; it is not queued.
- Byte-enable write: only lanes with byteEnable=1 are updated. byteEnable=0 on a write leaves memory unchanged and still returns read data.
- Same-port read-during-write:
  - READ_MODE 0 returns the pre-write word.
  - READ_MODE 1 returns the old word with the enabled lanes replaced by dataIn.
- Cross-port, same address:
  - A read on one port concurrent with a write on the other always returns the pre-write word.
- Write/write collision (same address, both ports):
  - Port A wins on overlapping lanes.
  - Non-overlapping lanes from B are still written.
  - collision pulses 1 on the following cycle only if lanes overlap.

## Timing
- Reset values:
  - dataOutA/B = 0
  - validA/B = 0
  - collision = 0
  - busy = 1
  - FSM = CLEAR
  - counter = 0
- OUTPUT_REG=0: request at edge n gives dataOut/valid at edge n+1.
- OUTPUT_REG=1: request at edge n gives dataOut/valid at edge n+2. The pipeline advances every cycle with no stall.
- dataOut holds its last value when valid=0; valid is a per-cycle flag, not sticky.
- busy falls at the edge after address DEPTH-1 is written. A request on that first IDLE cycle is accepted.
- collision is registered: it rises one cycle after the colliding writes and lasts one cycle.

## Structure
- Shared package sram_dp_pkg holds:
  - READ_FIRST/WRITE_THROUGH constants
  - clear FSM state typedef (CLEAR, IDLE)
  - function computing byte-merged words from (old, new, mask)
- Sub-module sram_dp_port, instantiated twice, holds:
  - byte-merge for READ_MODE
  - optional output register
  - valid pipeline
- Top level owns the array, the clear FSM, collision arbitration and write priority.

## Test plan
- Reset, then wait: busy=1 for exactly 1024 cycles (ADDR_WIDTH=10). Read addresses 0, 511 and 1023 on both ports: each returns CLEAR_VALUE=0, valid 1 cycle later.
- Port A writes 0xBEEF @5, byteEnable=2'b01. Port B reads @5: returns 0x00EF; prior word 0x0000 returned on A per READ_MODE=0.
- READ_MODE=1: A writes 0x1234 @7 with full enables. dataOutA = 0x1234 the same +1 cycle; B reading @7 in that cycle gets the old value.
- A writes 0xAAAA, B writes 0x5555 @9, both enables 2'b11: memory = 0xAAAA and collision pulses once. Repeat with A=2'b10, B=2'b01: memory = 0xAA55 and collision stays 0.
- OUTPUT_REG=1: back-to-back reads @1, @2, @3 give valid on three consecutive cycles, starting 2 cycles after the first request.
- Assert clearRequest, then drop resetN at clear cycle 300 and release it. busy stays 1 for a full 1024 further cycles; afterwards every word reads CLEAR_VALUE and earlier data is gone.
